// File: rtl/serial_to_parallel_rx_if.sv
// Serial receive bundle: serial bit in, recovered byte/strobe/lock out.
// S2P_BYTE_COUNT_EN adds the 16-bit delivered-byte counter.
interface serial_to_parallel_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef S2P_BYTE_COUNT_EN
    logic [15:0] byte_count;

    modport master (output data_in, input data_out, valid_out, active, byte_count);
    modport slave  (input data_in, output data_out, valid_out, active, byte_count);
`else
    modport master (output data_in, input data_out, valid_out, active);
    modport slave  (input data_in, output data_out, valid_out, active);
`endif
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Comma-aligned serial-to-parallel receiver on the 8x bit clock (MSB first).
// Optional S2P_BYTE_COUNT_EN: 16-bit wrapping count of delivered bytes.
module serial_to_parallel_rx #(
    parameter logic [7:0]  COMMA     = 8'hBC,
    parameter int unsigned BC_NEEDED = 4
) (
    input  logic                    clk_8f,
    input  logic                    reset,
    serial_to_parallel_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    localparam logic [3:0] BC_N = 4'(BC_NEEDED);

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nx;
    logic [2:0] r_bitcnt;
    logic [2:0] w_bitcnt_nx;
    logic [3:0] r_bc_cnt;
    logic [3:0] w_bc_cnt_nx;
    logic [7:0] r_data_out;
    logic [7:0] w_data_nx;
    logic       r_valid;
    logic       w_valid_nx;
    logic       r_active;
    logic       w_boundary;
    logic       w_is_comma;

    // The completed byte is the shift register including this edge's bit.
    always_comb begin
        w_shift_nx  = {r_shift[6:0], bus.data_in};
        w_boundary  = (r_bitcnt == 3'd7);
        w_is_comma  = (w_shift_nx == COMMA);
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt + 3'd1;
        w_bc_cnt_nx = r_bc_cnt;
        w_data_nx   = r_data_out;
        w_valid_nx  = 1'b0;

        case (r_state)
            SEARCH: begin
                if (w_is_comma) begin
                    w_bitcnt_nx = 3'd0;
                    w_bc_cnt_nx = 4'd1;
                    w_state_nx  = (BC_N == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_bc_cnt_nx = r_bc_cnt + 4'd1;
                        if (w_bc_cnt_nx == BC_N) begin
                            w_state_nx = ACTIVE;
                        end
                    end else begin
                        w_bc_cnt_nx = 4'd0;
                        w_state_nx  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (w_boundary && !w_is_comma) begin
                    w_data_nx  = w_shift_nx;
                    w_valid_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_state    <= SEARCH;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_bc_cnt   <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_bitcnt   <= w_bitcnt_nx;
            r_bc_cnt   <= w_bc_cnt_nx;
            r_data_out <= w_data_nx;
            r_valid    <= w_valid_nx;
            r_active   <= (w_state_nx == ACTIVE);
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid;
    assign bus.active    = r_active;

`ifdef S2P_BYTE_COUNT_EN
    logic [15:0] r_byte_count;

    // Counts in step with valid_out so the count already includes the strobed byte.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_byte_count <= '0;
        end else if (w_valid_nx) begin
            r_byte_count <= r_byte_count + 16'd1;
        end
    end

    assign bus.byte_count = r_byte_count;
`endif

endmodule
